node_path_counter: RTL

// Counts distinct paths from start node to end node of the device DAG. Sits downstream of

---
 rtl/node_path_counter.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/node_path_counter.sv
// node_path_counter: counts distinct start->end paths through a DAG.
// Edges are captured into a private store as they stream in; trimmed nodes
// arrive in topological order through a FIFO and each node's path count is
// pushed along its out-edges, one edge at a time, so no RAM hazards arise.
module node_path_counter #(
   parameter int  MAX_NODES    = 1024,
   parameter int  MAX_EDGES    = 2048,
   parameter int  FIFO_DEPTH   = 1024,
   parameter int  RESULT_WIDTH = 16,
   localparam int NODE_WIDTH   = $clog2(MAX_NODES),
   localparam int EDGE_WIDTH   = $clog2(MAX_EDGES),
   localparam int FIFO_AW      = $clog2(FIFO_DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    decoding_done,
   input  logic                    edge_valid,
   input  logic                    src_node_valid,
   input  logic [NODE_WIDTH-1:0]   src_node,
   input  logic [NODE_WIDTH-1:0]   dst_node,
   input  logic [NODE_WIDTH-1:0]   start_node_idx,
   input  logic [NODE_WIDTH-1:0]   end_node_idx,
   input  logic                    start_end_nodes_valid,
   input  logic                    trimed_done,
   input  logic                    trimed_valid,
   input  logic [NODE_WIDTH-1:0]   trimed_node,
   output logic                    path_count_valid,
   output logic [RESULT_WIDTH-1:0] path_count_value,
   output logic                    error
);

   typedef enum logic [3:0] {
      S_INIT, S_COLLECT, S_POP, S_SRC, S_EDGE,
      S_ACC_RD, S_ACC_WR, S_NEXT, S_RES_RD, S_DONE
   } state_t;

   state_t r_state, w_state_next;

   // Storage
   logic [RESULT_WIDTH-1:0] count_ram      [MAX_NODES];
   logic [EDGE_WIDTH:0]     edge_cnt_ram   [MAX_NODES];
   logic [EDGE_WIDTH-1:0]   first_edge_ram [MAX_NODES];
   logic [NODE_WIDTH-1:0]   edge_ram       [MAX_EDGES];
   logic [NODE_WIDTH-1:0]   fifo_ram       [FIFO_DEPTH];

   // Registered RAM read data
   logic [RESULT_WIDTH-1:0] r_count_rd;
   logic [EDGE_WIDTH:0]     r_ecnt_rd;
   logic [EDGE_WIDTH-1:0]   r_first_rd;
   logic [NODE_WIDTH-1:0]   r_edge_rd;
   logic [NODE_WIDTH-1:0]   r_fifo_head;

   // Control / datapath registers
   logic [NODE_WIDTH-1:0]   r_init_addr;
   logic [EDGE_WIDTH:0]     r_wr_ptr;
   logic [EDGE_WIDTH:0]     r_cur_cnt;
   logic [NODE_WIDTH-1:0]   r_start, r_end;
   logic                    r_se_latched;
   logic [FIFO_AW-1:0]      r_fifo_wr_ptr, r_fifo_rd_ptr;
   logic [FIFO_AW:0]        r_fifo_cnt;
   logic                    r_trim_done_seen, r_dec_done_seen;
   logic [NODE_WIDTH-1:0]   r_node;
   logic [RESULT_WIDTH-1:0] r_c;
   logic [EDGE_WIDTH-1:0]   r_e;
   logic [EDGE_WIDTH:0]     r_left;
   logic                    r_valid, r_error;
   logic [RESULT_WIDTH-1:0] r_value;

   // Combinational helpers
   logic                    w_active, w_edge_full, w_edge_wr, w_fifo_full, w_fifo_empty;
   logic                    w_push, w_pop, w_dec_seen;
   logic [EDGE_WIDTH:0]     w_new_cnt;
   logic                    w_cnt_we, w_ecnt_we;
   logic [NODE_WIDTH-1:0]   w_cnt_waddr, w_cnt_raddr, w_ecnt_waddr;
   logic [RESULT_WIDTH-1:0] w_cnt_wdata;
   logic [EDGE_WIDTH:0]     w_ecnt_wdata;

   assign w_active     = (r_state != S_INIT);
   assign w_edge_full  = (r_wr_ptr == (EDGE_WIDTH+1)'(MAX_EDGES));
   assign w_edge_wr    = w_active && edge_valid && !w_edge_full;
   assign w_fifo_full  = (r_fifo_cnt == (FIFO_AW+1)'(FIFO_DEPTH));
   assign w_fifo_empty = (r_fifo_cnt == '0);
   assign w_push       = w_active && trimed_valid && !w_fifo_full;
   assign w_pop        = (r_state == S_POP);
   assign w_dec_seen   = r_dec_done_seen || decoding_done;
   // Running edge count of the current source; edges of a source are contiguous
   assign w_new_cnt    = src_node_valid ? (EDGE_WIDTH+1)'(1) : r_cur_cnt + 1'b1;

   // RAM port muxing: INIT clears, otherwise the edge stream / accumulator own the ports
   always_comb begin
      w_cnt_we     = 1'b0;
      w_cnt_waddr  = r_edge_rd;
      w_cnt_wdata  = r_count_rd + r_c;
      w_ecnt_we    = 1'b0;
      w_ecnt_waddr = src_node;
      w_ecnt_wdata = w_new_cnt;
      w_cnt_raddr  = r_end;
      if (r_state == S_INIT) begin
         w_cnt_we     = 1'b1;
         w_cnt_waddr  = r_init_addr;
         w_cnt_wdata  = '0;
         w_ecnt_we    = 1'b1;
         w_ecnt_waddr = r_init_addr;
         w_ecnt_wdata = '0;
      end else begin
         w_ecnt_we = w_edge_wr;
         if (r_state == S_ACC_WR) w_cnt_we = 1'b1;
      end
      if (r_state == S_POP)         w_cnt_raddr = r_fifo_head;
      else if (r_state == S_ACC_RD) w_cnt_raddr = r_edge_rd;
   end

   // Path count RAM with registered read
   always_ff @(posedge clk) begin
      if (w_cnt_we) count_ram[w_cnt_waddr] <= w_cnt_wdata;
      r_count_rd <= count_ram[w_cnt_raddr];
   end

   // Per-source edge count RAM with registered read
   always_ff @(posedge clk) begin
      if (w_ecnt_we) edge_cnt_ram[w_ecnt_waddr] <= w_ecnt_wdata;
      r_ecnt_rd <= edge_cnt_ram[r_fifo_head];
   end

   // First-edge pointer RAM and edge destination RAM
   always_ff @(posedge clk) begin
      if (w_active && src_node_valid) first_edge_ram[src_node] <= r_wr_ptr[EDGE_WIDTH-1:0];
      if (w_edge_wr) edge_ram[r_wr_ptr[EDGE_WIDTH-1:0]] <= dst_node;
      r_first_rd <= first_edge_ram[r_fifo_head];
      r_edge_rd  <= edge_ram[r_e];
   end

   // Trim FIFO storage; head is re-read every cycle so it is valid one cycle after non-empty
   always_ff @(posedge clk) begin
      if (w_push) fifo_ram[r_fifo_wr_ptr] <= trimed_node;
      r_fifo_head <= fifo_ram[r_fifo_rd_ptr];
   end

   // State register and all control/datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state          <= S_INIT;
         r_init_addr      <= '0;
         r_wr_ptr         <= '0;
         r_cur_cnt        <= '0;
         r_start          <= '0;
         r_end            <= '0;
         r_se_latched     <= 1'b0;
         r_fifo_wr_ptr    <= '0;
         r_fifo_rd_ptr    <= '0;
         r_fifo_cnt       <= '0;
         r_trim_done_seen <= 1'b0;
         r_dec_done_seen  <= 1'b0;
         r_node           <= '0;
         r_c              <= '0;
         r_e              <= '0;
         r_left           <= '0;
         r_valid          <= 1'b0;
         r_value          <= '0;
         r_error          <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (r_state == S_INIT) r_init_addr <= r_init_addr + 1'b1;
         if (start_end_nodes_valid && !r_se_latched) begin
            r_start      <= start_node_idx;
            r_end        <= end_node_idx;
            r_se_latched <= 1'b1;
         end
         if (w_active && src_node_valid) r_cur_cnt <= w_edge_wr ? (EDGE_WIDTH+1)'(1) : '0;
         else if (w_edge_wr)             r_cur_cnt <= r_cur_cnt + 1'b1;
         if (w_edge_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_push) r_fifo_wr_ptr <= r_fifo_wr_ptr + 1'b1;
         if (w_pop)  r_fifo_rd_ptr <= r_fifo_rd_ptr + 1'b1;
         if (w_push && !w_pop)      r_fifo_cnt <= r_fifo_cnt + 1'b1;
         else if (!w_push && w_pop) r_fifo_cnt <= r_fifo_cnt - 1'b1;
         if (w_active && trimed_done)   r_trim_done_seen <= 1'b1;
         if (w_active && decoding_done) r_dec_done_seen  <= 1'b1;
         if (w_active && ((edge_valid && w_edge_full) || (trimed_valid && w_fifo_full)))
            r_error <= 1'b1;
         case (r_state)
            S_POP: r_node <= r_fifo_head;
            S_SRC: begin
               r_c    <= (r_node == r_start) ? RESULT_WIDTH'(1) : r_count_rd;
               r_e    <= r_first_rd;
               r_left <= r_ecnt_rd;
            end
            S_ACC_WR: begin
               r_e    <= r_e + 1'b1;
               r_left <= r_left - 1'b1;
            end
            S_DONE: begin
               if (!r_valid) begin
                  r_valid <= 1'b1;
                  r_value <= (r_end == r_start) ? RESULT_WIDTH'(1) : r_count_rd;
               end
            end
            default: ;
         endcase
      end
   end

   // Next-state logic of the processing FSM
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_INIT:    if (r_init_addr == NODE_WIDTH'(MAX_NODES-1)) w_state_next = S_COLLECT;
         S_COLLECT: begin
            if (w_dec_seen && !w_fifo_empty)          w_state_next = S_POP;
            else if (w_dec_seen && r_trim_done_seen)  w_state_next = S_RES_RD;
         end
         S_POP:     w_state_next = S_SRC;
         S_SRC:     w_state_next = (r_ecnt_rd == '0) ? S_NEXT : S_EDGE;
         S_EDGE:    w_state_next = S_ACC_RD;
         S_ACC_RD:  w_state_next = S_ACC_WR;
         S_ACC_WR:  w_state_next = (r_left == (EDGE_WIDTH+1)'(1)) ? S_NEXT : S_EDGE;
         S_NEXT: begin
            if (!w_fifo_empty)         w_state_next = S_POP;
            else if (r_trim_done_seen) w_state_next = S_RES_RD;
         end
         S_RES_RD:  w_state_next = S_DONE;
         S_DONE:    w_state_next = S_DONE;
         default:   w_state_next = S_INIT;
      endcase
   end

   assign path_count_valid = r_valid;
   assign path_count_value = r_value;
   assign error            = r_error;

endmodule
